// File: rtl/cam_pixel_packer.sv
// Camera byte-stream capture: pairs RGB565 bytes into 10-bit RGB343 pixels with line/frame bookkeeping.
// Pixel is presented with wr one cycle after its low byte; a full FIFO drops the pixel and counts it.
module cam_pixel_packer #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int CNT_W    = 10,
   parameter int OVF_W    = 16
) (
   input  logic             Pclk,
   input  logic             rst,
   input  logic             vsync,
   input  logic             href,
   input  logic [7:0]       d,
   input  logic             fifo_full,
   output logic [9:0]       data_out,
   output logic             wr,
   output logic             frame_done,
   output logic [CNT_W-1:0] line_cnt,
   output logic [OVF_W-1:0] overflow_cnt,
   output logic             line_err
);

   typedef enum logic [1:0] {WAIT_VSYNC, SYNC, ACTIVE, DONE} state_t;

   state_t           state_q, state_d;
   logic             phase_q, phase_d;
   logic [7:0]       hi_byte_q, hi_byte_d;
   logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
   logic [OVF_W-1:0] overflow_cnt_q, overflow_cnt_d;
   logic             line_err_q, line_err_d;
   logic [9:0]       data_out_q, data_out_d;
   logic             wr_q, wr_d;
   logic             vsync_dly_q, vsync_dly_d;
   logic             href_dly_q, href_dly_d;

   logic             vsync_fall;
   logic             href_fall;
   logic [CNT_W-1:0] line_inc;

   assign vsync_fall = vsync_dly_q & ~vsync;
   assign href_fall  = href_dly_q & ~href;
   assign line_inc   = line_cnt_q + CNT_W'(1);

   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      hi_byte_d      = hi_byte_q;
      pix_cnt_d      = pix_cnt_q;
      line_cnt_d     = line_cnt_q;
      overflow_cnt_d = overflow_cnt_q;
      line_err_d     = line_err_q;
      data_out_d     = data_out_q;
      wr_d           = 1'b0;
      vsync_dly_d    = vsync;
      href_dly_d     = href;

      case (state_q)
         WAIT_VSYNC: begin
            if (vsync) state_d = SYNC;
         end
         SYNC: begin
            // overflow_cnt deliberately survives frame boundaries
            if (vsync_fall) begin
               line_cnt_d = '0;
               pix_cnt_d  = '0;
               phase_d    = 1'b0;
               line_err_d = 1'b0;
               state_d    = ACTIVE;
            end
         end
         ACTIVE: begin
            if (href) begin
               if (!phase_q) begin
                  hi_byte_d = d;
                  phase_d   = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + CNT_W'(1);
                  if (!fifo_full) begin
                     data_out_d = {hi_byte_q[7:5], hi_byte_q[2:0], d[7], d[4:2]};
                     wr_d       = 1'b1;
                  end else if (overflow_cnt_q != '1) begin
                     overflow_cnt_d = overflow_cnt_q + OVF_W'(1);
                  end
               end
            end
            if (href_fall) begin
               line_cnt_d = line_inc;
               if (phase_q || (pix_cnt_q != CNT_W'(H_ACTIVE))) line_err_d = 1'b1;
               pix_cnt_d = '0;
               phase_d   = 1'b0;
            end
            // a line ending together with vsync rising is counted before the short-frame test
            if (href_fall && (line_inc == CNT_W'(V_ACTIVE))) begin
               state_d = DONE;
            end else if (vsync) begin
               line_err_d = 1'b1;
               state_d    = SYNC;
            end
         end
         DONE: begin
            state_d = WAIT_VSYNC;
         end
         default: begin
            state_d = WAIT_VSYNC;
         end
      endcase
   end

   always_ff @(posedge Pclk) begin
      if (rst) begin
         state_q        <= WAIT_VSYNC;
         phase_q        <= 1'b0;
         hi_byte_q      <= '0;
         pix_cnt_q      <= '0;
         line_cnt_q     <= '0;
         overflow_cnt_q <= '0;
         line_err_q     <= 1'b0;
         data_out_q     <= '0;
         wr_q           <= 1'b0;
         vsync_dly_q    <= 1'b0;
         href_dly_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         hi_byte_q      <= hi_byte_d;
         pix_cnt_q      <= pix_cnt_d;
         line_cnt_q     <= line_cnt_d;
         overflow_cnt_q <= overflow_cnt_d;
         line_err_q     <= line_err_d;
         data_out_q     <= data_out_d;
         wr_q           <= wr_d;
         vsync_dly_q    <= vsync_dly_d;
         href_dly_q     <= href_dly_d;
      end
   end

   assign data_out     = data_out_q;
   assign wr           = wr_q;
   assign frame_done   = (state_q == DONE);
   assign line_cnt     = line_cnt_q;
   assign overflow_cnt = overflow_cnt_q;
   assign line_err     = line_err_q;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed bench for cam_pixel_packer using a 4-pixel x 2-line geometry.
module tb_cam_pixel_packer;

   logic        Pclk;
   logic        rst;
   logic        vsync;
   logic        href;
   logic [7:0]  d;
   logic        fifo_full;
   logic [9:0]  data_out;
   logic        wr;
   logic        frame_done;
   logic [9:0]  line_cnt;
   logic [15:0] overflow_cnt;
   logic        line_err;

   int vectors;
   int miscompares;
   int wr_seen;
   int fd_seen;

   logic [7:0] hi_t  [4] = '{8'hF8, 8'h07, 8'h00, 8'hAB};
   logic [7:0] lo_t  [4] = '{8'h1F, 8'hE0, 8'h00, 8'hCD};
   logic [9:0] exp_t [4] = '{10'h387, 10'h078, 10'h000, 10'h2BB};

   cam_pixel_packer #(.H_ACTIVE(4), .V_ACTIVE(2), .CNT_W(10), .OVF_W(16)) dut (
      .Pclk(Pclk), .rst(rst), .vsync(vsync), .href(href), .d(d),
      .fifo_full(fifo_full), .data_out(data_out), .wr(wr),
      .frame_done(frame_done), .line_cnt(line_cnt),
      .overflow_cnt(overflow_cnt), .line_err(line_err)
   );

   initial Pclk = 1'b0;
   always #5 Pclk = ~Pclk;

   // Drive on the falling edge, then observe 1 time unit after the rising edge.
   task automatic cyc(input logic v, input logic h, input logic [7:0] b,
                      input logic ff, input logic r);
      @(negedge Pclk);
      vsync = v; href = h; d = b; fifo_full = ff; rst = r;
      @(posedge Pclk);
      #1;
      if (wr === 1'b1) wr_seen++;
      if (frame_done === 1'b1) fd_seen++;
   endtask

   task automatic do_reset();
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic start_frame();
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (wr !== 1'b0) begin miscompares++; $display("FAIL rst_wr: got %b want 0", wr); end
      vectors++; if (data_out !== 10'h000) begin miscompares++; $display("FAIL rst_data: got %h want 000", data_out); end
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_fd: got %b want 0", frame_done); end
      vectors++; if (line_cnt !== 10'd0) begin miscompares++; $display("FAIL rst_line_cnt: got %0d want 0", line_cnt); end
      vectors++; if (overflow_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_ovf: got %0d want 0", overflow_cnt); end
      vectors++; if (line_err !== 1'b0) begin miscompares++; $display("FAIL rst_line_err: got %b want 0", line_err); end
   endtask

   task automatic test_single_pixel();
      start_frame();
      cyc(1'b0, 1'b1, 8'hF8, 1'b0, 1'b0);
      vectors++; if (wr !== 1'b0) begin miscompares++; $display("FAIL single_hi_wr: got %b want 0", wr); end
      cyc(1'b0, 1'b1, 8'h1F, 1'b0, 1'b0);
      vectors++; if (wr !== 1'b1) begin miscompares++; $display("FAIL single_wr: got %b want 1", wr); end
      vectors++; if (data_out !== 10'h387) begin miscompares++; $display("FAIL single_data: got %h want 387", data_out); end
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      vectors++; if (wr !== 1'b0) begin miscompares++; $display("FAIL single_wr_drop: got %b want 0", wr); end
      vectors++; if (data_out !== 10'h387) begin miscompares++; $display("FAIL single_hold: got %h want 387", data_out); end
      vectors++; if (line_cnt !== 10'd1) begin miscompares++; $display("FAIL single_line_cnt: got %0d want 1", line_cnt); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      start_frame();
      cyc(1'b0, 1'b1, 8'h07, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'hE0, 1'b0, 1'b0);
      vectors++; if (wr !== 1'b1) begin miscompares++; $display("FAIL green_wr: got %b want 1", wr); end
      vectors++; if (data_out !== 10'h078) begin miscompares++; $display("FAIL green_data: got %h want 078", data_out); end
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      vectors++; if (wr !== 1'b0) begin miscompares++; $display("FAIL b2b_gap_wr: got %b want 0", wr); end
      vectors++; if (data_out !== 10'h078) begin miscompares++; $display("FAIL b2b_gap_hold: got %h want 078", data_out); end
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      vectors++; if (wr !== 1'b1) begin miscompares++; $display("FAIL b2b_wr: got %b want 1", wr); end
      vectors++; if (data_out !== 10'h000) begin miscompares++; $display("FAIL b2b_data: got %h want 000", data_out); end
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      vectors++; if (wr !== 1'b0) begin miscompares++; $display("FAIL b2b_end_wr: got %b want 0", wr); end
   endtask

   task automatic test_backpressure();
      do_reset();
      start_frame();
      wr_seen = 0;
      for (int p = 0; p < 3; p++) begin
         cyc(1'b0, 1'b1, hi_t[p], 1'b0, 1'b0);
         cyc(1'b0, 1'b1, lo_t[p], 1'b1, 1'b0);
      end
      vectors++; if (wr_seen !== 0) begin miscompares++; $display("FAIL bp_no_wr: got %0d pulses want 0", wr_seen); end
      vectors++; if (overflow_cnt !== 16'd3) begin miscompares++; $display("FAIL bp_ovf: got %0d want 3", overflow_cnt); end
      vectors++; if (data_out !== 10'h000) begin miscompares++; $display("FAIL bp_hold: got %h want 000", data_out); end
      cyc(1'b0, 1'b1, 8'hAB, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 8'hCD, 1'b0, 1'b0);
      vectors++; if (wr !== 1'b1) begin miscompares++; $display("FAIL bp_resume_wr: got %b want 1", wr); end
      vectors++; if (data_out !== 10'h2BB) begin miscompares++; $display("FAIL bp_resume_data: got %h want 2bb", data_out); end
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      vectors++; if (line_err !== 1'b0) begin miscompares++; $display("FAIL bp_line_ok: got %b want 0", line_err); end
      vectors++; if (line_cnt !== 10'd1) begin miscompares++; $display("FAIL bp_line_cnt: got %0d want 1", line_cnt); end
      // short frame: vsync returns after one of two lines
      fd_seen = 0;
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      vectors++; if (line_err !== 1'b1) begin miscompares++; $display("FAIL short_err: got %b want 1", line_err); end
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      vectors++; if (fd_seen !== 0) begin miscompares++; $display("FAIL short_no_fd: got %0d want 0", fd_seen); end
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      vectors++; if (line_err !== 1'b0) begin miscompares++; $display("FAIL newframe_err_clr: got %b want 0", line_err); end
      vectors++; if (line_cnt !== 10'd0) begin miscompares++; $display("FAIL newframe_line_clr: got %0d want 0", line_cnt); end
      vectors++; if (overflow_cnt !== 16'd3) begin miscompares++; $display("FAIL newframe_ovf_kept: got %0d want 3", overflow_cnt); end
   endtask

   task automatic test_full_frame();
      do_reset();
      start_frame();
      wr_seen = 0;
      fd_seen = 0;
      for (int ln = 0; ln < 2; ln++) begin
         for (int p = 0; p < 4; p++) begin
            cyc(1'b0, 1'b1, hi_t[p], 1'b0, 1'b0);
            cyc(1'b0, 1'b1, lo_t[p], 1'b0, 1'b0);
            vectors++; if (wr !== 1'b1 || data_out !== exp_t[p]) begin
               miscompares++;
               $display("FAIL frame_px L%0d P%0d: got wr=%b data=%h want wr=1 data=%h", ln, p, wr, data_out, exp_t[p]);
            end
         end
         cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
         if (ln == 0) begin
            vectors++; if (line_cnt !== 10'd1) begin miscompares++; $display("FAIL frame_line1: got %0d want 1", line_cnt); end
            vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL frame_early_fd: got %b want 0", frame_done); end
         end else begin
            vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL frame_fd: got %b want 1", frame_done); end
         end
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL frame_fd_pulse: got %b want 0", frame_done); end
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      vectors++; if (wr_seen !== 8) begin miscompares++; $display("FAIL frame_wr_count: got %0d want 8", wr_seen); end
      vectors++; if (fd_seen !== 1) begin miscompares++; $display("FAIL frame_fd_count: got %0d want 1", fd_seen); end
      vectors++; if (line_cnt !== 10'd2) begin miscompares++; $display("FAIL frame_line_hold: got %0d want 2", line_cnt); end
      vectors++; if (line_err !== 1'b0) begin miscompares++; $display("FAIL frame_err: got %b want 0", line_err); end
   endtask

   task automatic test_odd_line();
      do_reset();
      start_frame();
      for (int p = 0; p < 3; p++) begin
         cyc(1'b0, 1'b1, hi_t[p], 1'b0, 1'b0);
         cyc(1'b0, 1'b1, lo_t[p], 1'b0, 1'b0);
      end
      cyc(1'b0, 1'b1, 8'hAB, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      vectors++; if (line_err !== 1'b1) begin miscompares++; $display("FAIL odd_err: got %b want 1", line_err); end
      vectors++; if (line_cnt !== 10'd1) begin miscompares++; $display("FAIL odd_line_cnt: got %0d want 1", line_cnt); end
      cyc(1'b0, 1'b1, 8'hF8, 1'b0, 1'b0);
      vectors++; if (wr !== 1'b0) begin miscompares++; $display("FAIL odd_phase_wr: got %b want 0", wr); end
      cyc(1'b0, 1'b1, 8'h1F, 1'b0, 1'b0);
      vectors++; if (wr !== 1'b1 || data_out !== 10'h387) begin
         miscompares++; $display("FAIL odd_next_px: got wr=%b data=%h want wr=1 data=387", wr, data_out);
      end
      vectors++; if (line_err !== 1'b1) begin miscompares++; $display("FAIL odd_sticky: got %b want 1", line_err); end
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_line();
      do_reset();
      start_frame();
      cyc(1'b0, 1'b1, 8'hF8, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'h1F, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      vectors++; if (overflow_cnt !== 16'd1) begin miscompares++; $display("FAIL mid_pre_ovf: got %0d want 1", overflow_cnt); end
      cyc(1'b0, 1'b1, 8'hF8, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'h1F, 1'b0, 1'b1);
      vectors++; if (wr !== 1'b0) begin miscompares++; $display("FAIL mid_rst_wr: got %b want 0", wr); end
      vectors++; if (line_cnt !== 10'd0) begin miscompares++; $display("FAIL mid_rst_line: got %0d want 0", line_cnt); end
      vectors++; if (overflow_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_rst_ovf: got %0d want 0", overflow_cnt); end
      vectors++; if (line_err !== 1'b0) begin miscompares++; $display("FAIL mid_rst_err: got %b want 0", line_err); end
      wr_seen = 0;
      fd_seen = 0;
      cyc(1'b0, 1'b1, 8'h1F, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'hF8, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'h1F, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      vectors++; if (wr_seen !== 0) begin miscompares++; $display("FAIL mid_ignored_wr: got %0d pulses want 0", wr_seen); end
      vectors++; if (line_cnt !== 10'd0) begin miscompares++; $display("FAIL mid_ignored_line: got %0d want 0", line_cnt); end
      vectors++; if (fd_seen !== 0) begin miscompares++; $display("FAIL mid_ignored_fd: got %0d want 0", fd_seen); end
      start_frame();
      cyc(1'b0, 1'b1, 8'h07, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'hE0, 1'b0, 1'b0);
      vectors++; if (wr !== 1'b1 || data_out !== 10'h078) begin
         miscompares++; $display("FAIL mid_recover: got wr=%b data=%h want wr=1 data=078", wr, data_out);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      wr_seen     = 0;
      fd_seen     = 0;
      rst         = 1'b1;
      vsync       = 1'b0;
      href        = 1'b0;
      d           = 8'h00;
      fifo_full   = 1'b0;
      test_reset();
      test_single_pixel();
      test_back_to_back();
      test_backpressure();
      test_full_frame();
      test_odd_line();
      test_reset_mid_line();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
